alu_operand_stage: RTL

//  Issue stage directly upstream of the MIPS ALU. Holds the 32x32 register file,

---
 rtl/alu_operand_if.sv | 35 +++
 rtl/alu_operand_stage.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_operand_if.sv
// Issue-to-ALU bundle: instruction in, operands out, writeback return.
// The slave side is the operand stage; the master side drives it.
interface alu_operand_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              InstrValid;
  logic              InstrReady;
  logic [31:0]       Instr;
  logic [1:0]        ALUOp;
  logic              RegWrite;
  logic              RegDst;
  logic              ExValid;
  logic              ExReady;
  logic [3:0]        ALUCtl;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [ADDR_W-1:0] ExDest;
  logic              IllegalOp;
  logic              WbValid;
  logic [ADDR_W-1:0] WbAddr;
  logic [DATA_W-1:0] WbData;

  modport master (
    output InstrValid, Instr, ALUOp, RegWrite, RegDst,
    output ExReady, WbValid, WbAddr, WbData,
    input  InstrReady, ExValid, ALUCtl, A, B, ExDest, IllegalOp
  );

  modport slave (
    input  InstrValid, Instr, ALUOp, RegWrite, RegDst,
    input  ExReady, WbValid, WbAddr, WbData,
    output InstrReady, ExValid, ALUCtl, A, B, ExDest, IllegalOp
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand issue stage: register file, ALU control decode, RAW scoreboard
// and a one-entry registered output slot toward the ALU.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic reset,
  alu_operand_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] w_rs, w_rt, w_rd, w_dest;
  logic [5:0]        w_funct;
  logic [3:0]        w_ctl;
  logic              w_rs_byp, w_rt_byp;
  logic              w_hz, w_free, w_acc, w_wb;
  logic [DATA_W-1:0] w_a, w_b;

  logic [DATA_W-1:0] r_rf [NREG];
  logic [NREG-1:0]   r_pend;
  logic              r_exvalid;
  logic [3:0]        r_ctl;
  logic [DATA_W-1:0] r_a, r_b;
  logic [ADDR_W-1:0] r_dest;
  logic              r_ill;

  assign w_rs    = bus.Instr[21 +: ADDR_W];
  assign w_rt    = bus.Instr[16 +: ADDR_W];
  assign w_rd    = bus.Instr[11 +: ADDR_W];
  assign w_funct = bus.Instr[5:0];

  assign w_dest = !bus.RegWrite ? '0 :
                  bus.RegDst ? w_rd : w_rt;

  assign w_wb     = bus.WbValid && (bus.WbAddr != '0);
  assign w_rs_byp = bus.WbValid && (bus.WbAddr == w_rs);
  assign w_rt_byp = bus.WbValid && (bus.WbAddr == w_rt);

  // A result arriving this cycle resolves the hazard it would cause
  assign w_hz =
    ((w_rs != '0) && r_pend[w_rs] && !w_rs_byp) ||
    ((w_rt != '0) && r_pend[w_rt] && !w_rt_byp);

  assign w_a = (w_rs == '0) ? '0 :
               w_rs_byp ? bus.WbData : r_rf[w_rs];
  assign w_b = (w_rt == '0) ? '0 :
               w_rt_byp ? bus.WbData : r_rf[w_rt];

  assign w_free = !r_exvalid || bus.ExReady;
  assign w_acc  = bus.InstrValid && w_free && !w_hz;

  always_comb begin
    w_ctl = 4'd15;
    unique case (bus.ALUOp)
      2'b00: w_ctl = 4'd2;
      2'b01: w_ctl = 4'd6;
      2'b10: begin
        unique case (1'b1)
          (w_funct == 6'd32): w_ctl = 4'd2;
          (w_funct == 6'd34): w_ctl = 4'd6;
          (w_funct == 6'd36): w_ctl = 4'd0;
          (w_funct == 6'd37): w_ctl = 4'd1;
          (w_funct == 6'd39): w_ctl = 4'd12;
          (w_funct == 6'd42): w_ctl = 4'd7;
          default:            w_ctl = 4'd15;
        endcase
      end
      default: w_ctl = 4'd15;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_pend    <= '0;
      r_exvalid <= 1'b0;
      r_ctl     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_dest    <= '0;
      r_ill     <= 1'b0;
    end else begin
      if (w_wb) begin
        r_rf[bus.WbAddr]   <= bus.WbData;
        r_pend[bus.WbAddr] <= 1'b0;
      end
      // Issued later in program order, so the new set wins the tie
      if (w_acc && (w_dest != '0)) r_pend[w_dest] <= 1'b1;
      if (w_acc) begin
        r_exvalid <= 1'b1;
        r_ctl     <= w_ctl;
        r_a       <= w_a;
        r_b       <= w_b;
        r_dest    <= w_dest;
        r_ill     <= (w_ctl == 4'd15);
      end else if (bus.ExReady) begin
        r_exvalid <= 1'b0;
      end
    end
  end

  assign bus.InstrReady = w_free && !w_hz;
  assign bus.ExValid    = r_exvalid;
  assign bus.ALUCtl     = r_ctl;
  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.ExDest     = r_dest;
  assign bus.IllegalOp  = r_ill;
endmodule
